// File: rtl/timer_run_ctrl.sv
// Run control for the two-digit BCD countdown timer: button edges,
// 1 s prescaler, count/reload strobes and the blinking alarm.
module timer_run_ctrl #(
    parameter int unsigned TICK_DIV    = 40000000,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       set_sw,
    input  logic       time_zero,
    output logic       decrease,
    output logic       setting,
    output logic       reload,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] CNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_END = BW'(ALARM_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt;
    logic [BW-1:0] r_blink;
    logic [BW-1:0] w_blink;
    logic [BW-1:0] w_blink_inc;
    logic          r_alarm;
    logic          w_alarm;
    logic          r_dec;
    logic          w_dec;
    logic          r_reload;
    logic          w_reload;
    logic          r_setting;
    logic          r_start_d1;
    logic          r_clear_d1;
    logic          r_rdy;
    logic          w_start_e;
    logic          w_clear_e;
    logic          w_counting;
    logic          w_tick;

    // r_rdy masks the first cycle so a button held through reset is no edge
    assign w_start_e = btn_start & ~r_start_d1 & r_rdy;
    assign w_clear_e = btn_clear & ~r_clear_d1 & r_rdy;

    assign w_counting  = (r_state == S_RUN) || (r_state == S_DONE);
    assign w_tick      = w_counting && (r_cnt == CNT_MAX);
    assign w_blink_inc = r_blink + BW'(1);

    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_blink  = r_blink;
        w_alarm  = r_alarm;
        w_dec    = 1'b0;
        w_reload = 1'b0;
        if (w_counting) begin
            w_cnt = w_tick ? '0 : r_cnt + PW'(1);
        end
        if (w_clear_e) begin
            w_next   = S_IDLE;
            w_cnt    = '0;
            w_blink  = '0;
            w_alarm  = 1'b0;
            w_reload = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_e) begin
                        if (!time_zero) begin
                            w_next = S_RUN;
                            w_cnt  = '0;
                        end
                    end else if (set_sw) begin
                        w_next = S_SET;
                    end
                end
                S_SET: begin
                    if (!set_sw) w_next = S_IDLE;
                end
                S_RUN: begin
                    if (w_start_e) begin
                        w_next = S_PAUSE;
                        w_cnt  = r_cnt;
                    end else if (w_tick) begin
                        if (time_zero) begin
                            w_next  = S_DONE;
                            w_alarm = 1'b1;
                            w_blink = '0;
                        end else begin
                            w_dec = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_start_e) w_next = S_RUN;
                end
                S_DONE: begin
                    if (w_start_e) begin
                        w_next  = S_IDLE;
                        w_alarm = 1'b0;
                        w_cnt   = r_cnt;
                    end else if (w_tick) begin
                        w_blink = w_blink_inc;
                        if (w_blink_inc == BLINK_END) begin
                            w_next  = S_IDLE;
                            w_alarm = 1'b0;
                        end else begin
                            w_alarm = ~r_alarm;
                        end
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_blink    <= '0;
            r_alarm    <= 1'b0;
            r_dec      <= 1'b0;
            r_reload   <= 1'b0;
            r_setting  <= 1'b0;
            r_start_d1 <= 1'b0;
            r_clear_d1 <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt;
            r_blink    <= w_blink;
            r_alarm    <= w_alarm;
            r_dec      <= w_dec;
            r_reload   <= w_reload;
            r_setting  <= (w_next == S_SET);
            r_start_d1 <= btn_start;
            r_clear_d1 <= btn_clear;
            r_rdy      <= 1'b1;
        end
    end

    assign decrease = r_dec;
    assign setting  = r_setting;
    assign reload   = r_reload;
    assign alarm    = r_alarm;
    assign state    = r_state;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed + random bench for timer_run_ctrl against a
// cycle-level behavioural model of the run-control rules.
module tb_timer_run_ctrl;

    localparam int TD = 4;
    localparam int AT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       set_sw = 1'b0;
    logic       time_zero = 1'b0;
    logic       decrease;
    logic       setting;
    logic       reload;
    logic       alarm;
    logic [2:0] state;

    int n_err = 0;
    int n_checks = 0;

    // model: mode 0 idle,1 set,2 run,3 pause,4 done
    int m_mode, m_frac, m_blink;
    bit m_dec, m_rel, m_alarm;
    bit m_ps, m_pc, m_first;

    timer_run_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start(btn_start), .btn_clear(btn_clear),
        .set_sw(set_sw), .time_zero(time_zero),
        .decrease(decrease), .setting(setting),
        .reload(reload), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_frac = 0; m_blink = 0;
        m_dec = 0; m_rel = 0; m_alarm = 0;
        m_ps = 0; m_pc = 0; m_first = 1;
    endtask

    task automatic model_clock();
        bit se, ce, run_like, tick;
        int nf;
        se = btn_start && !m_ps && !m_first;
        ce = btn_clear && !m_pc && !m_first;
        run_like = (m_mode == 2) || (m_mode == 4);
        tick = run_like && (m_frac == TD - 1);
        nf = run_like ? (m_frac + 1) % TD : m_frac;
        m_dec = 0;
        m_rel = 0;
        if (ce) begin
            m_mode = 0; nf = 0; m_alarm = 0; m_blink = 0; m_rel = 1;
        end else if (m_mode == 0) begin
            if (se) begin
                if (!time_zero) begin m_mode = 2; nf = 0; end
            end else if (set_sw) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!set_sw) m_mode = 0;
        end else if (m_mode == 2) begin
            if (se) begin
                m_mode = 3; nf = m_frac;
            end else if (tick) begin
                if (time_zero) begin
                    m_mode = 4; m_alarm = 1; m_blink = 0;
                end else m_dec = 1;
            end
        end else if (m_mode == 3) begin
            if (se) m_mode = 2;
        end else begin
            if (se) begin
                m_mode = 0; m_alarm = 0; nf = m_frac;
            end else if (tick) begin
                m_blink++;
                if (m_blink == AT) begin
                    m_mode = 0; m_alarm = 0;
                end else m_alarm = !m_alarm;
            end
        end
        m_frac = nf;
        m_ps = btn_start;
        m_pc = btn_clear;
        m_first = 0;
    endtask

    task automatic check_all(input string tag);
        logic [6:0] obs, exp;
        obs = {state, decrease, setting, reload, alarm};
        exp = {3'(m_mode), m_dec, (m_mode == 1), m_rel, m_alarm};
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag = "model");
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc("press");
        btn_start = 1'b0;
        cyc("release");
    endtask

    int cnt;
    int seen;

    initial begin
        do_reset();
        chk("reset_state", state, 0);
        cyc();

        // 1: run, decrease every TD clocks
        btn_start = 1'b1;
        cyc("s1_press");
        btn_start = 1'b0;
        chk("s1_state", state, 2);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc("s1");
            cnt += int'(decrease);
        end
        chk("s1_dec_count", cnt, 3);

        // 2: pause mid-period, no decrease while paused
        cyc("s2");
        cyc("s2");
        press_start();
        chk("s2_paused", state, 3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc("s2_pause");
            cnt += int'(decrease);
        end
        chk("s2_no_dec", cnt, 0);
        press_start();
        for (int i = 0; i < 6; i++) cyc("s2_resume");

        // 3: reaching zero -> DONE, blink, auto return
        time_zero = 1'b1;
        seen = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("s3");
            if (state == 3'd4) seen = 1;
            cnt += int'(decrease);
        end
        chk("s3_done_seen", seen, 1);
        chk("s3_no_dec", cnt, 0);
        chk("s3_idle", state, 0);
        chk("s3_alarm_off", alarm, 0);
        press_start();
        chk("s3_zero_start", state, 0);
        time_zero = 1'b0;

        // 4: clear beats start
        press_start();
        for (int i = 0; i < 5; i++) cyc("s4_run");
        btn_clear = 1'b1;
        btn_start = 1'b1;
        cyc("s4_both");
        chk("s4_state", state, 0);
        chk("s4_reload", reload, 1);
        chk("s4_dec", decrease, 0);
        btn_clear = 1'b0;
        btn_start = 1'b0;
        cyc("s4_after");
        chk("s4_reload_1cyc", reload, 0);

        // 5: set mode
        set_sw = 1'b1;
        cyc("s5_set");
        chk("s5_setting", setting, 1);
        press_start();
        chk("s5_start_ign", state, 1);
        set_sw = 1'b0;
        cyc("s5_unset");
        chk("s5_idle", state, 0);

        // 6: button held through reset; reset mid-run
        btn_start = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) cyc("s6_held");
        chk("s6_held_idle", state, 0);
        btn_start = 1'b0;
        cyc();
        press_start();
        for (int i = 0; i < 3; i++) cyc("s6_run");
        chk("s6_running", state, 2);
        do_reset();
        chk("s6_mid_reset", {state, decrease, reload, alarm}, 0);
        cyc();

        // random phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 30) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 25) == 0) set_sw = ~set_sw;
            time_zero = ($urandom_range(0, 3) == 0);
            cyc("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
